// File: rtl/fifo_uart_pkg.sv
// Shared definitions for the FIFO-fed UART transmitter: FSM states, data width
// and a helper that gives the frame length in clock cycles.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam int DATA_BITS = 8;

  // Cycles from the first START cycle through the last STOP cycle.
  function automatic int frame_cycles(int clks, int par, int stop);
    return (1 + DATA_BITS + par + stop) * clks;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while run is high and flags the
// last cycle of each serial bit.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic bit_end
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (run) begin
      count <= (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign bit_end = run && (count == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pulls one byte per frame from an upstream synchronous
// FIFO and shifts it out LSB-first with start, optional parity and stop bits.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_enable,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_data,
  output logic       rd_en,
  output logic       txd,
  output logic       busy,
  output logic       frame_done
);

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_STOP = 3'(STOP_BITS - 1);

  tx_state_t  state, state_d;
  logic [7:0] shift, shift_d;
  logic [2:0] bit_idx, bit_idx_d;
  logic       parity, parity_d;
  logic       txd_d;
  logic       timer_clear, timer_run, bit_end;

  function automatic logic parity_bit(logic [7:0] b);
    return (^b) ^ (PARITY_ODD != 0);
  endfunction

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .run    (timer_run),
    .bit_end(bit_end)
  );

  assign timer_run = (state == START) || (state == DATA) ||
                     (state == PARITY) || (state == STOP);
  assign rd_en = (state == FETCH);
  assign busy  = (state != IDLE);

  always_comb begin
    state_d     = state;
    shift_d     = shift;
    bit_idx_d   = bit_idx;
    parity_d    = parity;
    timer_clear = 1'b0;
    frame_done  = 1'b0;
    txd_d       = 1'b1;

    case (state)
      IDLE:   if (tx_enable && !fifo_empty) state_d = FETCH;
      FETCH:  state_d = LOAD;
      LOAD: begin
        shift_d  = fifo_data;
        parity_d = parity_bit(fifo_data);
        state_d  = START;
      end
      START:  if (bit_end) state_d = DATA;
      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift[7:1]};
          if (bit_idx == LAST_BIT) state_d = (PARITY_EN != 0) ? PARITY : STOP;
          else                     bit_idx_d = bit_idx + 1'b1;
        end
      end
      PARITY: if (bit_end) state_d = STOP;
      STOP: begin
        if (bit_end) begin
          if (bit_idx == LAST_STOP) begin
            state_d    = IDLE;
            frame_done = 1'b1;
          end else begin
            bit_idx_d = bit_idx + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Every state entry restarts both the bit timer and the bit index.
    if (state_d != state) begin
      timer_clear = 1'b1;
      bit_idx_d   = '0;
    end

    // txd is registered from the next-state view so the pin changes exactly
    // at the state boundary without a decode path to the output.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      PARITY:  txd_d = parity_d;
      default: txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      shift   <= '0;
      bit_idx <= '0;
      parity  <= 1'b0;
      txd     <= 1'b1;
    end else begin
      state   <= state_d;
      shift   <= shift_d;
      bit_idx <= bit_idx_d;
      parity  <= parity_d;
      txd     <= txd_d;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx: four instances cover no parity, two stop
// bits, even parity and odd parity, each fed by a small FIFO model.
module tb_fifo_uart_tx;
  import fifo_uart_pkg::*;

  logic clk;
  logic rst;
  logic tx_en;
  logic [3:0] txd_v, rd_v, busy_v, done_v;

  int checks = 0;
  int errors = 0;
  int rd_cnt [4] = '{0, 0, 0, 0};

  // FIFO model for instance 0 (registered read data)
  logic [7:0] fa_mem [0:15];
  int         fa_wp = 0, fa_rp = 0;
  logic [7:0] fa_q = '0;
  logic       hold_a = 1'b0;
  logic       empty_a;
  assign empty_a = (fa_wp == fa_rp) || hold_a;

  // FIFO model for instance 1
  logic [7:0] fs_mem [0:15];
  int         fs_wp = 0, fs_rp = 0;
  logic [7:0] fs_q = '0;
  logic       empty_s;
  assign empty_s = (fs_wp == fs_rp);

  // Shared single-byte feeder for the two parity instances
  logic [7:0] pbyte = '0;
  logic [7:0] pp_q = '0;
  logic       pp_empty = 1'b1;

  always @(posedge clk) begin
    if (rd_v[0]) begin
      fa_q  <= fa_mem[fa_rp];
      fa_rp <= fa_rp + 1;
    end
    if (rd_v[1]) begin
      fs_q  <= fs_mem[fs_rp];
      fs_rp <= fs_rp + 1;
    end
    if (rd_v[2]) pp_q <= pbyte;
    for (int k = 0; k < 4; k++) if (rd_v[k]) rd_cnt[k] <= rd_cnt[k] + 1;
  end

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .tx_enable(tx_en), .fifo_empty(empty_a), .fifo_data(fa_q),
    .rd_en(rd_v[0]), .txd(txd_v[0]), .busy(busy_v[0]), .frame_done(done_v[0]));

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) dut_s (
    .clk(clk), .rst(rst), .tx_enable(tx_en), .fifo_empty(empty_s), .fifo_data(fs_q),
    .rd_en(rd_v[1]), .txd(txd_v[1]), .busy(busy_v[1]), .frame_done(done_v[1]));

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) dut_e (
    .clk(clk), .rst(rst), .tx_enable(tx_en), .fifo_empty(pp_empty), .fifo_data(pp_q),
    .rd_en(rd_v[2]), .txd(txd_v[2]), .busy(busy_v[2]), .frame_done(done_v[2]));

  fifo_uart_tx #(.CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) dut_o (
    .clk(clk), .rst(rst), .tx_enable(tx_en), .fifo_empty(pp_empty), .fifo_data(pp_q),
    .rd_en(rd_v[3]), .txd(txd_v[3]), .busy(busy_v[3]), .frame_done(done_v[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_a(logic [7:0] b);
    fa_mem[fa_wp] = b;
    fa_wp = fa_wp + 1;
  endtask

  task automatic push_s(logic [7:0] b);
    fs_mem[fs_wp] = b;
    fs_wp = fs_wp + 1;
  endtask

  // Bounded wait for the read strobe of instance d.
  task automatic wait_rd(int d);
    int n = 0;
    while (!rd_v[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("rd_wait%0d", d), rd_v[d], 1);
  endtask

  // Called on the first START cycle; ends on the last stop cycle.
  task automatic check_frame(int d, logic [7:0] b, int par_en, logic par_bit,
                             int stops, int drop_at);
    int n = frame_cycles(4, par_en, stops);
    for (int i = 0; i < n; i++) begin
      int  bitn = i / 4;
      logic e;
      if (bitn == 0)                  e = 1'b0;
      else if (bitn <= 8)             e = b[bitn-1];
      else if (par_en && bitn == 9)   e = par_bit;
      else                            e = 1'b1;
      chk($sformatf("txd%0d_%02h_c%0d", d, b, i), txd_v[d], e);
      chk($sformatf("done%0d_%02h_c%0d", d, b, i), done_v[d], (i == n - 1));
      if (i == drop_at) tx_en = 1'b0;
      if (i < n - 1) @(negedge clk);
    end
  endtask

  // IDLE, FETCH, LOAD after a frame, leaving the bench on the next START cycle.
  task automatic gap(int d);
    @(negedge clk);
    chk($sformatf("gap_idle%0d", d), {rd_v[d], txd_v[d]}, 2'b01);
    @(negedge clk);
    chk($sformatf("gap_fetch%0d", d), {rd_v[d], txd_v[d]}, 2'b11);
    @(negedge clk);
    chk($sformatf("gap_load%0d", d), {rd_v[d], txd_v[d]}, 2'b01);
    @(negedge clk);
  endtask

  initial begin
    rst   = 1'b0;
    tx_en = 1'b1;
    @(negedge clk);
    @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("rst_txd%0d", d), txd_v[d], 1);
      chk($sformatf("rst_rd%0d", d), rd_v[d], 0);
      chk($sformatf("rst_busy%0d", d), busy_v[d], 0);
      chk($sformatf("rst_done%0d", d), done_v[d], 0);
    end
    rst = 1'b1;
    @(negedge clk);

    // Single byte 0xA5, no parity, one stop bit
    push_a(8'hA5);
    wait_rd(0);
    chk("busy_rise", busy_v[0], 1);
    @(negedge clk);
    chk("load_txd", {rd_v[0], txd_v[0]}, 2'b01);
    @(negedge clk);
    check_frame(0, 8'hA5, 0, 1'b0, 1, -1);
    @(negedge clk);
    chk("a5_end", {busy_v[0], txd_v[0], done_v[0]}, 3'b010);
    chk("a5_rdcnt", rd_cnt[0], 1);

    // Parity: even/odd on 0xA5 (0/1) and on 0x07 (1/0)
    pbyte    = 8'hA5;
    pp_empty = 1'b0;
    wait_rd(2);
    pp_empty = 1'b0;
    pp_empty = 1'b1;
    chk("par_rd_odd_a5", rd_v[3], 1);
    @(negedge clk);
    @(negedge clk);
    fork
      check_frame(2, 8'hA5, 1, 1'b0, 1, -1);
      check_frame(3, 8'hA5, 1, 1'b1, 1, -1);
    join
    @(negedge clk);
    pbyte    = 8'h07;
    pp_empty = 1'b0;
    wait_rd(2);
    pp_empty = 1'b1;
    chk("par_rd_odd_07", rd_v[3], 1);
    @(negedge clk);
    @(negedge clk);
    fork
      check_frame(2, 8'h07, 1, 1'b1, 1, -1);
      check_frame(3, 8'h07, 1, 1'b0, 1, -1);
    join
    @(negedge clk);
    chk("par_rdcnt", {rd_cnt[2][7:0], rd_cnt[3][7:0]}, 16'h0202);

    // Two stop bits, three queued bytes back to back
    push_s(8'h00);
    push_s(8'hFF);
    push_s(8'h3C);
    wait_rd(1);
    @(negedge clk);
    @(negedge clk);
    check_frame(1, 8'h00, 0, 1'b0, 2, -1);
    gap(1);
    check_frame(1, 8'hFF, 0, 1'b0, 2, -1);
    gap(1);
    check_frame(1, 8'h3C, 0, 1'b0, 2, -1);
    repeat (5) begin
      @(negedge clk);
      chk("s_idle", {rd_v[1], busy_v[1], txd_v[1]}, 3'b001);
    end
    chk("s_rdcnt", rd_cnt[1], 3);
    chk("s_empty", empty_s, 1);

    // tx_enable dropped mid-frame with a second byte queued
    push_a(8'h81);
    push_a(8'h42);
    wait_rd(0);
    @(negedge clk);
    @(negedge clk);
    check_frame(0, 8'h81, 0, 1'b0, 1, 10);
    repeat (20) begin
      @(negedge clk);
      chk("hold_idle", {rd_v[0], busy_v[0], txd_v[0]}, 3'b001);
    end
    chk("hold_rdcnt", rd_cnt[0], 2);
    tx_en = 1'b1;
    wait_rd(0);
    @(negedge clk);
    @(negedge clk);
    check_frame(0, 8'h42, 0, 1'b0, 1, -1);
    @(negedge clk);
    chk("resume_rdcnt", rd_cnt[0], 3);

    // fifo_empty low for a single IDLE cycle
    hold_a = 1'b1;
    push_a(8'hC3);
    repeat (3) begin
      @(negedge clk);
      chk("held_rd", rd_v[0], 0);
    end
    hold_a = 1'b0;
    @(negedge clk);
    hold_a = 1'b1;
    chk("pulse_rd", rd_v[0], 1);
    @(negedge clk);
    chk("pulse_load", {rd_v[0], txd_v[0]}, 2'b01);
    @(negedge clk);
    check_frame(0, 8'hC3, 0, 1'b0, 1, -1);
    repeat (10) begin
      @(negedge clk);
      chk("pulse_idle", {rd_v[0], busy_v[0], txd_v[0]}, 3'b001);
    end
    chk("pulse_rdcnt", rd_cnt[0], 4);

    // Reset during the first data bit of 0x5A (bit 0 = 0)
    hold_a = 1'b0;
    push_a(8'h5A);
    wait_rd(0);
    @(negedge clk);
    @(negedge clk);
    repeat (5) @(negedge clk);
    chk("pre_rst_txd", txd_v[0], 0);
    rst = 1'b0;
    #1;
    chk("mid_rst", {rd_v[0], busy_v[0], txd_v[0], done_v[0]}, 4'b0010);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (30) begin
      @(negedge clk);
      chk("post_rst", {rd_v[0], busy_v[0], txd_v[0]}, 3'b001);
    end
    chk("post_rst_rdcnt", rd_cnt[0], 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Byte-serial transmit stage that drains the 8-bit synchronous FIFO and drives an asynchronous serial (UART) line. It sits directly downstream of the FIFO:
- it watches `fifo_empty`;
- it pulses `rd_en` once per byte;
- it captures the FIFO's registered `Data_out`;
- it shifts the byte out LSB-first with start, optional parity and stop bits.

One byte is fetched per frame. The FIFO is never read while a frame is in progress.

## Interface
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; legal range ≥ 2.
- `PARITY_EN`, 0: 1 inserts a parity bit after bit 7.
- `PARITY_ODD`, 0: 0 selects even parity, 1 selects odd; ignored when `PARITY_EN` = 0.
- `STOP_BITS`, 1: number of stop bits, 1 or 2.
- `clk` input 1: single clock; all logic on its rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `tx_enable` input 1: when high, new frames may start.
- `fifo_empty` input 1: empty flag from the upstream FIFO.
- `fifo_data` input 8: FIFO `Data_out`; valid the cycle after `rd_en` is sampled.
- `rd_en` output 1: one-cycle read strobe to the FIFO.
- `txd` output 1: serial line; idle level is 1.
- `busy` output 1: high from fetch until the end of the last stop bit.
- `frame_done` output 1: one-cycle pulse in the final cycle of the last stop bit.

## Operation
- States: IDLE, FETCH, LOAD, START, DATA, PARITY, STOP.
- IDLE → FETCH when `tx_enable` = 1 and `fifo_empty` = 0 are sampled together. Otherwise the block stays in IDLE.
- FETCH lasts one cycle with `rd_en` = 1. `rd_en` is 0 in every other state. Next state is LOAD.
- LOAD lasts one cycle. `fifo_data` is captured into an 8-bit shift register and parity is computed from it. Next state is START.
- START lasts `CLKS_PER_BIT` cycles with `txd` = 0.
- DATA lasts 8 × `CLKS_PER_BIT` cycles. `txd` = shift[0], and the register shifts right at each bit boundary.
- PARITY lasts `CLKS_PER_BIT` cycles and is present only if `PARITY_EN` = 1. `txd` = XOR of the data bits, inverted when `PARITY_ODD` = 1.
- STOP lasts `STOP_BITS` × `CLKS_PER_BIT` cycles with `txd` = 1. `frame_done` pulses in its last cycle. Next state is IDLE, always.
- Bit timer: counts 0 … `CLKS_PER_BIT` − 1 and wraps. Bit index counter: 0 … 7. Both clear on every state entry.
- `txd` is a registered output; no combinational path from state to pin.
- `fifo_empty` and `tx_enable` are sampled only in IDLE.
- Deasserting `tx_enable` mid-frame does not abort the frame. The frame completes and no new fetch follows.
- Reset asserted mid-frame takes effect immediately. `txd` = 1, `rd_en` = 0, `busy` = 0, `frame_done` = 0, state = IDLE. The partial frame is abandoned and no recovery is attempted.
- On release of reset the block returns to normal operation and the byte in flight is lost.

## Timing
- Reset values: `txd` = 1, `rd_en` = 0, `busy` = 0, `frame_done` = 0, shift register = 0, counters = 0.
- Let edge E be the edge at which IDLE samples the start condition.
  - `rd_en` is high in cycle E+1.
  - `busy` rises at E+1.
  - `txd` falls at E+3, the first START cycle.
- Frame length from START entry: (1 + 8 + `PARITY_EN` + `STOP_BITS`) × `CLKS_PER_BIT` cycles.
- Back-to-back frames have exactly 3 idle-high cycles between the last stop cycle and the next start bit (IDLE, FETCH, LOAD).
- Throughput: one byte per frame length + 3 cycles.
- At most one `rd_en` pulse per frame, so the FIFO is never read when empty.

## Structure
- Shared package `fifo_uart_pkg`:
  - state enum `tx_state_t`;
  - constant `DATA_BITS` = 8;
  - function `frame_cycles(clks, par, stop)` for bench and RTL use.
- One sub-module, `uart_bit_timer`:
  - parameterised by `CLKS_PER_BIT`;
  - inputs `clear` and `run`;
  - output `bit_end`, a one-cycle pulse when the count reaches `CLKS_PER_BIT` − 1.
- The top level holds the FSM, shift register, bit index and parity register.

## Test plan
- Single byte, `CLKS_PER_BIT` = 4, no parity, 1 stop. FIFO holds 0xA5 and `tx_enable` = 1.
  - One `rd_en` pulse.
  - `txd` = 0 (start), then 1,0,1,0,0,1,0,1, then 1 (stop), each 4 cycles.
  - `frame_done` pulses once and `busy` falls.
- Even parity on 0xA5 → parity bit 0. Odd parity on 0x07 → parity bit 0. Even parity on 0x07 → parity bit 1.
- `STOP_BITS` = 2, `CLKS_PER_BIT` = 4, three bytes 0x00, 0xFF, 0x3C queued.
  - Each frame is 44 cycles.
  - Exactly 3 idle-high cycles between frames.
  - Exactly three `rd_en` pulses, then IDLE with `fifo_empty` = 1.
- `tx_enable` dropped during the DATA state of byte 1 with two bytes queued.
  - Byte 1 completes and no further `rd_en` occurs.
  - Re-asserting `tx_enable` resumes with byte 2.
- Reset asserted during the DATA state of byte 0x5A.
  - `txd` is 1 in the same cycle and `rd_en` = 0.
  - After release, with an empty FIFO, `txd` stays 1 and `busy` stays 0.
- `fifo_empty` deasserted for exactly one IDLE cycle → exactly one fetch, and `txd` falls 2 cycles after the `rd_en` cycle.
